ps2_snake_cmd: RTL

PS2_SNAKE_CMD -- requirements
Module: ps2_snake_cmd

---
 rtl/snake_pkg.sv | 70 +++++++
 rtl/ps2_rx.sv | 131 +++++++++++++
 rtl/ps2_snake_cmd.sv | 72 +++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared snake-game definitions: command encodings, keyboard scan codes,
// PS/2 prefix bytes and the receiver state type.
package snake_pkg;

    localparam int unsigned CMD_W  = 4;
    localparam int unsigned BYTE_W = 8;

    // Game command encodings; 8-15 are reserved and never produced
    localparam logic [CMD_W-1:0] CMD_NONE  = 4'd0;
    localparam logic [CMD_W-1:0] CMD_UP    = 4'd1;
    localparam logic [CMD_W-1:0] CMD_DOWN  = 4'd2;
    localparam logic [CMD_W-1:0] CMD_LEFT  = 4'd3;
    localparam logic [CMD_W-1:0] CMD_RIGHT = 4'd4;
    localparam logic [CMD_W-1:0] CMD_START = 4'd5;
    localparam logic [CMD_W-1:0] CMD_PAUSE = 4'd6;
    localparam logic [CMD_W-1:0] CMD_QUIT  = 4'd7;

    // Set-2 make codes
    localparam logic [BYTE_W-1:0] SC_W       = 8'h1D;
    localparam logic [BYTE_W-1:0] SC_S       = 8'h1B;
    localparam logic [BYTE_W-1:0] SC_A       = 8'h1C;
    localparam logic [BYTE_W-1:0] SC_D       = 8'h23;
    localparam logic [BYTE_W-1:0] SC_ENTER   = 8'h5A;
    localparam logic [BYTE_W-1:0] SC_P       = 8'h4D;
    localparam logic [BYTE_W-1:0] SC_ESC     = 8'h76;
    localparam logic [BYTE_W-1:0] SC_E_UP    = 8'h75;
    localparam logic [BYTE_W-1:0] SC_E_DOWN  = 8'h72;
    localparam logic [BYTE_W-1:0] SC_E_LEFT  = 8'h6B;
    localparam logic [BYTE_W-1:0] SC_E_RIGHT = 8'h74;

    // PS/2 prefix bytes
    localparam logic [BYTE_W-1:0] PS2_EXT = 8'hE0;
    localparam logic [BYTE_W-1:0] PS2_BRK = 8'hF0;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    // Map a make code (with E0-prefix flag) to a game command; CMD_NONE if unmapped
    function automatic logic [CMD_W-1:0] map_scancode(input logic ext,
                                                      input logic [BYTE_W-1:0] code);
        logic [CMD_W-1:0] cmd;
        cmd = CMD_NONE;
        if (ext) begin
            case (code)
                SC_E_UP:    cmd = CMD_UP;
                SC_E_DOWN:  cmd = CMD_DOWN;
                SC_E_LEFT:  cmd = CMD_LEFT;
                SC_E_RIGHT: cmd = CMD_RIGHT;
                default:    cmd = CMD_NONE;
            endcase
        end else begin
            case (code)
                SC_W:     cmd = CMD_UP;
                SC_S:     cmd = CMD_DOWN;
                SC_A:     cmd = CMD_LEFT;
                SC_D:     cmd = CMD_RIGHT;
                SC_ENTER: cmd = CMD_START;
                SC_P:     cmd = CMD_PAUSE;
                SC_ESC:   cmd = CMD_QUIT;
                default:  cmd = CMD_NONE;
            endcase
        end
        return cmd;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 byte receiver: input synchronizers, frame FSM, idle timeout.
// Produces a one-cycle byte_valid with the received byte, or a frame_err pulse.
module ps2_rx
    import snake_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    output logic [BYTE_W-1:0] rx_byte,
    output logic              byte_valid,
    output logic              frame_err
);

    localparam int unsigned IDLE_W = 17;
    localparam logic [IDLE_W-1:0] TIMEOUT_VAL = IDLE_W'(TIMEOUT_CYCLES);

    logic clk_s1, clk_s2, clk_prev;
    logic dat_s1, dat_s2;
    logic fall_c, timeout_c;

    logic [IDLE_W-1:0] idle_cnt;

    rx_state_t         state, state_n;
    logic [2:0]        bit_cnt, bit_cnt_n;
    logic [BYTE_W-1:0] shift, shift_n;
    logic              par_ok, par_ok_n;
    logic [BYTE_W-1:0] rx_byte_n;
    logic              byte_valid_n, frame_err_n;

    // Two-flop synchronizers plus previous-clock flop for edge detect
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_data;
            dat_s2   <= dat_s1;
        end
    end

    assign fall_c    = clk_prev & ~clk_s2;
    // An edge arriving on the expiry cycle wins over the timeout
    assign timeout_c = ~fall_c && (idle_cnt == TIMEOUT_VAL) && (state != RX_IDLE);

    // Idle counter: cleared by each falling edge, saturates at the timeout value
    always_ff @(posedge clock) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (fall_c) begin
            idle_cnt <= '0;
        end else if (idle_cnt != TIMEOUT_VAL) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    // FSM state and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= RX_IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            par_ok     <= 1'b0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            par_ok     <= par_ok_n;
            rx_byte    <= rx_byte_n;
            byte_valid <= byte_valid_n;
            frame_err  <= frame_err_n;
        end
    end

    // Next-state: advance one bit per falling PS/2 clock edge
    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift;
        par_ok_n     = par_ok;
        rx_byte_n    = rx_byte;
        byte_valid_n = 1'b0;
        frame_err_n  = 1'b0;
        if (timeout_c) begin
            state_n     = RX_IDLE;
            bit_cnt_n   = '0;
            shift_n     = '0;
            frame_err_n = 1'b1;
        end else if (fall_c) begin
            case (state)
                RX_IDLE: begin
                    if (!dat_s2) begin
                        state_n   = RX_DATA;
                        bit_cnt_n = '0;
                    end
                end
                RX_DATA: begin
                    shift_n   = {dat_s2, shift[BYTE_W-1:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = RX_PARITY;
                end
                RX_PARITY: begin
                    par_ok_n = ^{dat_s2, shift};
                    state_n  = RX_STOP;
                end
                RX_STOP: begin
                    if (dat_s2 && par_ok) begin
                        rx_byte_n    = shift;
                        byte_valid_n = 1'b1;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                    state_n = RX_IDLE;
                end
                default: state_n = RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ps2_snake_cmd.sv
// PS/2 keyboard to snake-game command decoder: handles E0/F0 prefixes and
// maps make codes to commands held until the next mapped key.
module ps2_snake_cmd
    import snake_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              PS2Clk,
    input  logic              PS2Data,
    output logic [CMD_W-1:0]  command,
    output logic              cmd_valid,
    output logic [BYTE_W-1:0] scancode,
    output logic              frame_err
);

    logic [BYTE_W-1:0] rx_byte;
    logic              rx_valid;
    logic              rx_err;
    logic              ext, brk;
    logic [CMD_W-1:0]  map_c;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clock      (clock),
        .reset      (reset),
        .ps2_clk    (PS2Clk),
        .ps2_data   (PS2Data),
        .rx_byte    (rx_byte),
        .byte_valid (rx_valid),
        .frame_err  (rx_err)
    );

    assign frame_err = rx_err;
    assign map_c     = map_scancode(ext, rx_byte);

    // Prefix tracking and command/scancode update on each received byte
    always_ff @(posedge clock) begin
        if (reset) begin
            ext       <= 1'b0;
            brk       <= 1'b0;
            command   <= CMD_NONE;
            cmd_valid <= 1'b0;
            scancode  <= '0;
        end else begin
            cmd_valid <= 1'b0;
            if (rx_err) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (rx_valid) begin
                if (rx_byte == PS2_EXT) begin
                    ext <= 1'b1;
                end else if (rx_byte == PS2_BRK) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (!brk) begin
                        scancode <= rx_byte;
                        if (map_c != CMD_NONE) begin
                            command   <= map_c;
                            cmd_valid <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule
